wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of the register-file write port.
REQ-002 Parameter AW, default 5: register address width; 2**AW registers.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port a_valid / a_ready  input / output  1 / 1: requester A (ALU writeback) handshake.
REQ-006 Port a_rd_addr / a_rd_data  input  AW / XLEN: requester A destination and value.
REQ-007 Port b_valid / b_ready  input / output  1 / 1: requester B (load/multicycle unit) handshake.
REQ-008 Port b_rd_addr / b_rd_data  input  AW / XLEN: requester B destination and value.
REQ-009 Port iss_valid / iss_rd_addr  input  1 / AW: issue stage marks a destination as pending.
REQ-010 Port RegWEn / rd_addr / rd_data  output  1 / AW / XLEN: registered write command to the register file.
REQ-011 Port busy  output  2**AW: scoreboard; bit i = register i has a pending write.

Function
REQ-012 Handshake: a transfer occurs in the cycle where valid and ready are both 1; ready is combinational from the valids and arbitration state.
REQ-013 At most one of a_ready, b_ready is 1 per cycle; a lone valid requester is granted in that cycle.
REQ-014 When both are valid, grant goes to the requester not granted last (round-robin); the last-grant pointer updates only on a transfer.
REQ-015 A transfer in cycle N drives RegWEn=1, rd_addr, rd_data with the granted values in cycle N+1; with no transfer in N, RegWEn=0 in N+1 and rd_addr/rd_data hold.
REQ-016 A transfer with rd_addr 0 completes the handshake but produces RegWEn=0.
REQ-017 iss_valid with iss_rd_addr k!=0 sets busy[k] at the next edge; iss_rd_addr 0 sets nothing.
REQ-018 A transfer to address k clears busy[k] at the next edge.
REQ-019 Same-cycle set and clear of the same k: set wins; busy[k]=1.
REQ-020 busy[0] is constant 0.
REQ-021 Requester valid/addr/data are stable from valid rise until the transfer; dropping valid without a transfer is a protocol error, flagged by a bench assertion.

Reset
REQ-022 While rst=1 at an edge: RegWEn=0, rd_addr=0, rd_data=0, busy=0, last-grant=B (A wins the first tie).
REQ-023 a_ready=b_ready=0 in any cycle with rst=1; no transfer completes during reset.
REQ-024 Reset mid-operation discards the in-flight write; RegWEn is 0 in the cycle after reset is sampled.

Configuration
REQ-025 Macro WB_ROUND_ROBIN_EN defined: arbitration per REQ-014.
REQ-026 WB_ROUND_ROBIN_EN undefined: fixed priority, A always wins ties; the last-grant pointer is not implemented; all other requirements unchanged.

Structure
REQ-027 Package wb_pkg holds XLEN/AW defaults and the requester-id encoding (REQ_A=0, REQ_B=1).
REQ-028 Two-way arbitration lives in sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]), including the WB_ROUND_ROBIN_EN selection.
REQ-029 The scoreboard and output register stay in wb_port_arbiter.

Verification
REQ-030 Reset, then a_valid=1 addr 5 data 0xDEADBEEF: a_ready=1 the same cycle; next cycle RegWEn=1, rd_addr=5, rd_data=0xDEADBEEF.
REQ-031 Both valid for 4 cycles (A addr 1, B addr 2): grants A,B,A,B with RR enabled; A,A,A,A with WB_ROUND_ROBIN_EN undefined.
REQ-032 iss_valid addr 7, then B writes addr 7 two cycles later: busy[7]=1 for exactly 2 cycles, then 0.
REQ-033 iss_valid addr 3 in the same cycle as an A transfer to addr 3: busy[3]=1 afterwards.
REQ-034 A transfer to addr 0 with data 0x1234: a_ready=1 and RegWEn=0 in the next cycle; iss to addr 0 leaves busy=0.
REQ-035 rst asserted in the cycle after a transfer: RegWEn=0, busy=0, and the next tie grants A.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and requester ids for the writeback port arbiter.
// Optional round-robin arbitration is enabled with WB_ROUND_ROBIN_EN.
package wb_pkg;

   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way writeback arbiter: round-robin when WB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with requester A winning ties.
module rr_arb2
   import wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

`ifdef WB_ROUND_ROBIN_EN
   req_id_e last_q;

   always_comb begin
      gnt = req;
      if (&req)
         gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_q <= REQ_B;
      else if (advance)
         last_q <= gnt[1] ? REQ_B : REQ_A;
   end
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst, advance};
   assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by ALU and load writeback, plus the
// pending-write scoreboard. Arbitration mode set by WB_ROUND_ROBIN_EN.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [AW-1:0]     a_rd_addr,
   input  logic [XLEN-1:0]   a_rd_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [AW-1:0]     b_rd_addr,
   input  logic [XLEN-1:0]   b_rd_data,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd_addr,
   output logic              RegWEn,
   output logic [AW-1:0]     rd_addr,
   output logic [XLEN-1:0]   rd_data,
   output logic [2**AW-1:0]  busy
);

   localparam int NR = 2**AW;

   logic [1:0]      req;
   logic [1:0]      gnt;
   logic            xfer;
   logic [AW-1:0]   w_addr;
   logic [XLEN-1:0] w_data;
   logic [NR-1:0]   set_m;
   logic [NR-1:0]   clr_m;
   logic [NR-1:0]   busy_q;

   // No requester may be granted while reset is asserted.
   assign req = {b_valid, a_valid} & {2{~rst}};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (xfer),
      .gnt     (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];
   assign xfer    = (a_valid & a_ready) | (b_valid & b_ready);
   assign w_addr  = b_ready ? b_rd_addr : a_rd_addr;
   assign w_data  = b_ready ? b_rd_data : a_rd_data;

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (iss_valid)
         set_m[iss_rd_addr] = 1'b1;
      if (xfer)
         clr_m[w_addr] = 1'b1;
      set_m[0] = 1'b0;
   end

   // Set is applied after clear so a same-cycle issue keeps the bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWEn  <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
         busy_q  <= '0;
      end else begin
         RegWEn <= xfer && (w_addr != '0);
         if (xfer) begin
            rd_addr <= w_addr;
            rd_data <= w_data;
         end
         busy_q <= (busy_q & ~clr_m) | set_m;
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a
// behavioural reference model.
module tb_wb_port_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NR   = 2**AW;

   logic            clk = 1'b0;
   logic            rst;
   logic            a_valid, a_ready;
   logic [AW-1:0]   a_rd_addr;
   logic [XLEN-1:0] a_rd_data;
   logic            b_valid, b_ready;
   logic [AW-1:0]   b_rd_addr;
   logic [XLEN-1:0] b_rd_data;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd_addr;
   logic            RegWEn;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;
   logic [NR-1:0]   busy;

   wb_port_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_rd_addr   (a_rd_addr),
      .a_rd_data   (a_rd_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_rd_addr   (b_rd_addr),
      .b_rd_data   (b_rd_data),
      .iss_valid   (iss_valid),
      .iss_rd_addr (iss_rd_addr),
      .RegWEn      (RegWEn),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   a_hold: assert property (@(posedge clk) disable iff (rst)
      a_valid && !a_ready |=> a_valid && $stable(a_rd_addr) && $stable(a_rd_data));
   b_hold: assert property (@(posedge clk) disable iff (rst)
      b_valid && !b_ready |=> b_valid && $stable(b_rd_addr) && $stable(b_rd_data));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: 0 = A granted last, 1 = B granted last
   int            m_last;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [XLEN-1:0] m_data;
   logic [NR-1:0] m_busy;
   logic          o_ardy, o_brdy;
   logic          xa, xb;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r,
                       input logic av, input logic [AW-1:0] aa,
                       input logic [XLEN-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba,
                       input logic [XLEN-1:0] bd,
                       input logic iv, input logic [AW-1:0] ia);
      logic ga, gb;
      logic [AW-1:0] wa;
      @(negedge clk);
      rst = r;
      a_valid = av; a_rd_addr = aa; a_rd_data = ad;
      b_valid = bv; b_rd_addr = ba; b_rd_data = bd;
      iss_valid = iv; iss_rd_addr = ia;
      #1;
      if (r) begin
         ga = 1'b0; gb = 1'b0;
      end else if (av && bv) begin
`ifdef WB_ROUND_ROBIN_EN
         ga = (m_last == 1);
`else
         ga = 1'b1;
`endif
         gb = !ga;
      end else begin
         ga = av; gb = bv;
      end
      o_ardy = a_ready;
      o_brdy = b_ready;
      chk("a_ready", 64'(a_ready), 64'(ga));
      chk("b_ready", 64'(b_ready), 64'(gb));
      xa = ga && av;
      xb = gb && bv;
      @(posedge clk);
      #1;
      if (r) begin
         m_we = 1'b0; m_addr = '0; m_data = '0;
         m_busy = '0; m_last = 1;
      end else begin
         m_we = 1'b0;
         if (xa || xb) begin
            wa = xa ? aa : ba;
            m_addr = wa;
            m_data = xa ? ad : bd;
            m_we = (wa != 0);
            m_last = xa ? 0 : 1;
            if (wa != 0) m_busy[wa] = 1'b0;
         end
         if (iv && ia != 0) m_busy[ia] = 1'b1;
      end
      chk("RegWEn", 64'(RegWEn), 64'(m_we));
      chk("busy", 64'(busy), 64'(m_busy));
      if (m_we || r) begin
         chk("rd_addr", 64'(rd_addr), 64'(m_addr));
         chk("rd_data", 64'(rd_data), 64'(m_data));
      end
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, '0, '0, 0, '0);
   endtask

   task automatic do_rst();
      step(1, 0, '0, '0, 0, '0, '0, 0, '0);
   endtask

   logic [3:0] exp_seq;
   logic          pa, pb;
   logic [AW-1:0] paa, pba;
   logic [XLEN-1:0] pad, pbd;

   initial begin
      rst = 1'b1;
      a_valid = 0; a_rd_addr = '0; a_rd_data = '0;
      b_valid = 0; b_rd_addr = '0; b_rd_data = '0;
      iss_valid = 0; iss_rd_addr = '0;
      m_last = 1; m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;

      do_rst();
      do_rst();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_we", 64'(RegWEn), 64'd0);

      // Single A write
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0);
      chk("a_lone_ready", 64'(o_ardy), 64'd1);
      chk("a_lone_we", 64'(RegWEn), 64'd1);
      chk("a_lone_addr", 64'(rd_addr), 64'd5);
      chk("a_lone_data", 64'(rd_data), 64'hDEADBEEF);

      // Tie sequence from reset
      do_rst();
`ifdef WB_ROUND_ROBIN_EN
      exp_seq = 4'b0101;
`else
      exp_seq = 4'b1111;
`endif
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, '0);
         chk("tie_grant_a", 64'(o_ardy), 64'(exp_seq[i]));
      end
`ifndef WB_ROUND_ROBIN_EN
      step(0, 0, '0, '0, 1, 5'd2, 32'h22, 0, '0);
`endif
      idle();

      // Scoreboard set then cleared by B two cycles later
      do_rst();
      step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7);
      chk("busy7_c1", 64'(busy[7]), 64'd1);
      idle();
      chk("busy7_c2", 64'(busy[7]), 64'd1);
      step(0, 0, '0, '0, 1, 5'd7, 32'h77, 0, '0);
      chk("busy7_clr", 64'(busy[7]), 64'd0);

      // Same-cycle set and clear
      step(0, 1, 5'd3, 32'h33, 0, '0, '0, 1, 5'd3);
      chk("busy3_setwins", 64'(busy[3]), 64'd1);

      // Address zero
      do_rst();
      step(0, 1, 5'd0, 32'h1234, 0, '0, '0, 1, 5'd0);
      chk("z_ready", 64'(o_ardy), 64'd1);
      chk("z_we", 64'(RegWEn), 64'd0);
      chk("z_busy", 64'(busy), 64'd0);

      // Reset right after a transfer
      step(0, 1, 5'd9, 32'h99, 0, '0, '0, 1, 5'd4);
      step(1, 0, '0, '0, 0, '0, '0, 0, '0);
      chk("mid_rst_we", 64'(RegWEn), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      step(0, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, '0);
      chk("mid_rst_tie", 64'(o_ardy), 64'd1);
      step(0, 0, '0, '0, 1, 5'd8, 32'h88, 0, '0);

      // Random traffic
      pa = 0; pb = 0;
      paa = '0; pba = '0; pad = '0; pbd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!pa && ($urandom_range(2) == 0)) begin
            pa = 1; paa = AW'($urandom_range(9)); pad = $urandom;
         end
         if (!pb && ($urandom_range(2) == 0)) begin
            pb = 1; pba = AW'($urandom_range(9)); pbd = $urandom;
         end
         step(($urandom_range(60) == 0), pa, paa, pad, pb, pba, pbd,
              ($urandom_range(2) == 0), AW'($urandom_range(9)));
         if (xa) pa = 0;
         if (xb) pb = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
